// File: rtl/regbank_gen.sv
// regbank_gen: parametrised general-purpose register bank.
//
// Two combinational read ports and one synchronous byte-enabled write port.
// Optionally register 0 is hard-wired to zero, and a read of the register
// being written this cycle can return the merged new value (bypass). A
// per-register busy scoreboard tracks pending writebacks. busy_count is a
// registered population count of the busy bits, maintained incrementally.
//
// Ports:
//   CLK, RST                     clock, synchronous active-high reset
//   ENA_WRITE/WRITE_REG/
//   WRITE_DATA/WRITE_BE          write port (byte enables, clears busy)
//   READREG_1/READREG_2          read addresses
//   MARK_BUSY/MARK_REG           set busy bit of MARK_REG
//   read_data1/2, busy1/2        combinational read results
//   busy_count                   number of busy registers (registered)
module regbank_gen #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                ENA_WRITE,
    input  logic [ADDR_W-1:0]   WRITE_REG,
    input  logic [DATA_W-1:0]   WRITE_DATA,
    input  logic [DATA_W/8-1:0] WRITE_BE,
    input  logic [ADDR_W-1:0]   READREG_1,
    input  logic [ADDR_W-1:0]   READREG_2,
    input  logic                MARK_BUSY,
    input  logic [ADDR_W-1:0]   MARK_REG,
    output logic [DATA_W-1:0]   read_data1,
    output logic [DATA_W-1:0]   read_data2,
    output logic                busy1,
    output logic                busy2,
    output logic [ADDR_W:0]     busy_count
);
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int NBYTES = DATA_W / 8;
    localparam logic [ADDR_W:0] CNT_ONE = 1;

    logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
    logic [DEPTH-1:0]             busy_q, busy_d;
    logic [ADDR_W:0]              cnt_q, cnt_d;

    logic              wr_en;
    logic              mk_en;
    logic [DATA_W-1:0] wr_merged;

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // Operations are dropped during reset and when aimed at the zero register,
    // so the bypass path never shows data that will not actually land.
    assign wr_en = ENA_WRITE && !RST && !is_zero_reg(WRITE_REG);
    assign mk_en = MARK_BUSY && !RST && !is_zero_reg(MARK_REG);

    // Stored word of the write target with enabled bytes replaced; shared by
    // the write path and the bypass path.
    always_comb begin
        wr_merged = mem_q[WRITE_REG];
        for (int k = 0; k < NBYTES; k++) begin
            if (WRITE_BE[k]) wr_merged[8*k +: 8] = WRITE_DATA[8*k +: 8];
        end
    end

    always_comb begin
        mem_d  = mem_q;
        busy_d = busy_q;
        cnt_d  = cnt_q;
        if (wr_en) begin
            mem_d[WRITE_REG]  = wr_merged;
            busy_d[WRITE_REG] = 1'b0;
        end
        // Mark applied after the write so it wins on the same register.
        if (mk_en) busy_d[MARK_REG] = 1'b1;
        // Count tracks the net change of the busy vector: a mark only counts
        // if the bit was clear; a write only counts if the bit was set and
        // is not being re-marked in the same cycle.
        if (mk_en && !busy_q[MARK_REG]) cnt_d = cnt_d + CNT_ONE;
        if (wr_en && busy_q[WRITE_REG] && !(mk_en && (MARK_REG == WRITE_REG)))
            cnt_d = cnt_d - CNT_ONE;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            mem_q  <= '0;
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    task automatic read_port(input  logic [ADDR_W-1:0] ra,
                             output logic [DATA_W-1:0] rd,
                             output logic              bsy);
        rd  = mem_q[ra];
        bsy = busy_q[ra];
        if (is_zero_reg(ra)) begin
            rd  = '0;
            bsy = 1'b0;
        end else if ((BYPASS != 0) && wr_en && (ra == WRITE_REG)) begin
            rd  = wr_merged;
            bsy = mk_en && (MARK_REG == ra);
        end
    endtask

    always_comb begin
        read_data1 = '0;
        busy1      = 1'b0;
        read_port(READREG_1, read_data1, busy1);
    end

    always_comb begin
        read_data2 = '0;
        busy2      = 1'b0;
        read_port(READREG_2, read_data2, busy2);
    end

    assign busy_count = cnt_q;
endmodule

// File: tb/tb_regbank_gen.sv
module tb_regbank_gen;
    logic        CLK = 1'b0;
    logic        RST, ENA_WRITE, MARK_BUSY;
    logic [4:0]  WRITE_REG, READREG_1, READREG_2, MARK_REG;
    logic [31:0] WRITE_DATA;
    logic [3:0]  WRITE_BE;

    logic [31:0] u0_rd1, u0_rd2, u1_rd1, u1_rd2;
    logic        u0_b1, u0_b2, u1_b1, u1_b2;
    logic [5:0]  u0_cnt, u1_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    // u0: zero register + bypass; u1: no zero register, no bypass.
    regbank_gen u0 (
        .CLK(CLK), .RST(RST), .ENA_WRITE(ENA_WRITE), .WRITE_REG(WRITE_REG),
        .WRITE_DATA(WRITE_DATA), .WRITE_BE(WRITE_BE), .READREG_1(READREG_1),
        .READREG_2(READREG_2), .MARK_BUSY(MARK_BUSY), .MARK_REG(MARK_REG),
        .read_data1(u0_rd1), .read_data2(u0_rd2), .busy1(u0_b1), .busy2(u0_b2),
        .busy_count(u0_cnt));

    regbank_gen #(.ZERO_REG(0), .BYPASS(0)) u1 (
        .CLK(CLK), .RST(RST), .ENA_WRITE(ENA_WRITE), .WRITE_REG(WRITE_REG),
        .WRITE_DATA(WRITE_DATA), .WRITE_BE(WRITE_BE), .READREG_1(READREG_1),
        .READREG_2(READREG_2), .MARK_BUSY(MARK_BUSY), .MARK_REG(MARK_REG),
        .read_data1(u1_rd1), .read_data2(u1_rd2), .busy1(u1_b1), .busy2(u1_b2),
        .busy_count(u1_cnt));

    // Reference model: plain arrays of words and busy flags per instance.
    logic [31:0] m_mem  [2][32];
    logic        m_busy [2][32];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = wd[8*k +: 8];
        return r;
    endfunction

    function automatic int model_count(input int inst);
        int c;
        c = 0;
        for (int r = 0; r < 32; r++) if (m_busy[inst][r]) c++;
        return c;
    endfunction

    task automatic model_read(input int inst, input logic [4:0] ra,
                              output logic [31:0] d, output logic b);
        bit zero, byp;
        zero = (inst == 0);
        byp  = (inst == 0);
        if (zero && ra == 0) begin
            d = 0; b = 0;
        end else if (byp && ENA_WRITE && !RST && ra == WRITE_REG) begin
            d = merge(m_mem[inst][ra], WRITE_DATA, WRITE_BE);
            b = MARK_BUSY && (MARK_REG == ra);
        end else begin
            d = m_mem[inst][ra];
            b = m_busy[inst][ra];
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            if (RST) begin
                for (int r = 0; r < 32; r++) begin
                    m_mem[i][r]  = 0;
                    m_busy[i][r] = 0;
                end
            end else begin
                if (ENA_WRITE && !(i == 0 && WRITE_REG == 0)) begin
                    m_mem[i][WRITE_REG]  = merge(m_mem[i][WRITE_REG], WRITE_DATA, WRITE_BE);
                    m_busy[i][WRITE_REG] = 0;
                end
                if (MARK_BUSY && !(i == 0 && MARK_REG == 0)) m_busy[i][MARK_REG] = 1;
            end
        end
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] d1, d2;
        logic        b1, b2;
        for (int i = 0; i < 2; i++) begin
            model_read(i, READREG_1, d1, b1);
            model_read(i, READREG_2, d2, b2);
            cmp($sformatf("%s u%0d rd1[r%0d]", tag, i, READREG_1), i == 0 ? u0_rd1 : u1_rd1, d1);
            cmp($sformatf("%s u%0d rd2[r%0d]", tag, i, READREG_2), i == 0 ? u0_rd2 : u1_rd2, d2);
            cmp($sformatf("%s u%0d busy1", tag, i), {31'b0, i == 0 ? u0_b1 : u1_b1}, {31'b0, b1});
            cmp($sformatf("%s u%0d busy2", tag, i), {31'b0, i == 0 ? u0_b2 : u1_b2}, {31'b0, b2});
            cmp($sformatf("%s u%0d busy_count", tag, i),
                {26'b0, i == 0 ? u0_cnt : u1_cnt}, 32'(model_count(i)));
        end
    endtask

    task automatic idle();
        RST = 0; ENA_WRITE = 0; MARK_BUSY = 0;
    endtask

    // One clock: drive, check comb outputs mid-cycle, clock, update model.
    task automatic cyc(input logic r, input logic e, input logic [4:0] w,
                       input logic [31:0] d, input logic [3:0] b, input logic m,
                       input logic [4:0] mr, input logic [4:0] a1, input logic [4:0] a2);
        RST = r; ENA_WRITE = e; WRITE_REG = w; WRITE_DATA = d; WRITE_BE = b;
        MARK_BUSY = m; MARK_REG = mr; READREG_1 = a1; READREG_2 = a2;
        @(negedge CLK);
        check_all("pre");
        @(posedge CLK);
        model_edge();
        #1;
        idle();
    endtask

    task automatic do_reset();
        idle();
        RST = 1;
        repeat (2) @(posedge CLK);
        model_edge();
        #1;
        idle();
    endtask

    typedef struct {
        logic        rst, en;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic [3:0]  be;
        logic        mk;
        logic [4:0]  mr, ra1;
        logic [31:0] x_rd;
        logic        x_b;
        logic [5:0]  x_cnt;
    } vec_t;

    function automatic vec_t mkv(input logic rst, input logic en, input logic [4:0] wr,
                                 input logic [31:0] wd, input logic [3:0] be, input logic mk,
                                 input logic [4:0] mr, input logic [4:0] ra1,
                                 input logic [31:0] x_rd, input logic x_b, input logic [5:0] x_cnt);
        vec_t v;
        v.rst = rst; v.en = en; v.wr = wr; v.wd = wd; v.be = be; v.mk = mk;
        v.mr = mr; v.ra1 = ra1; v.x_rd = x_rd; v.x_b = x_b; v.x_cnt = x_cnt;
        return v;
    endfunction

    vec_t tbl[17];

    initial begin
        // Expected values are post-edge state of u0 (zero reg, bypass).
        //             rst en  wr  wd            be    mk  mr  ra1  x_rd          x_b x_cnt
        tbl[0]  = mkv(0, 1,  5, 32'hDEADBEEF, 4'hF, 0,  0,  5, 32'hDEADBEEF, 0, 0);
        tbl[1]  = mkv(0, 0,  0, 32'h0,        4'h0, 1,  5,  5, 32'hDEADBEEF, 1, 1);
        tbl[2]  = mkv(1, 1,  5, 32'h12345678, 4'hF, 1,  6,  5, 32'h0,        0, 0);
        tbl[3]  = mkv(0, 1,  3, 32'h11223344, 4'hF, 0,  0,  3, 32'h11223344, 0, 0);
        tbl[4]  = mkv(0, 0,  0, 32'h0,        4'h0, 1,  3,  3, 32'h11223344, 1, 1);
        tbl[5]  = mkv(0, 1,  3, 32'hAABBCCDD, 4'h5, 0,  0,  3, 32'h11BB33DD, 0, 0);
        tbl[6]  = mkv(0, 0,  0, 32'h0,        4'h0, 1,  3,  3, 32'h11BB33DD, 1, 1);
        tbl[7]  = mkv(0, 1,  3, 32'hFFFFFFFF, 4'h0, 0,  0,  3, 32'h11BB33DD, 0, 0);
        tbl[8]  = mkv(0, 1,  0, 32'hFFFFFFFF, 4'hF, 0,  0,  0, 32'h0,        0, 0);
        tbl[9]  = mkv(0, 0,  0, 32'h0,        4'h0, 1,  0,  0, 32'h0,        0, 0);
        tbl[10] = mkv(0, 0,  0, 32'h0,        4'h0, 1,  4,  4, 32'h0,        1, 1);
        tbl[11] = mkv(0, 0,  0, 32'h0,        4'h0, 1,  9,  4, 32'h0,        1, 2);
        tbl[12] = mkv(0, 0,  0, 32'h0,        4'h0, 1,  4,  4, 32'h0,        1, 2);
        tbl[13] = mkv(0, 1,  9, 32'h9,        4'hF, 0,  0,  9, 32'h9,        0, 1);
        tbl[14] = mkv(0, 1,  4, 32'h44,       4'hF, 1,  4,  4, 32'h44,       1, 1);
        tbl[15] = mkv(0, 1,  4, 32'h55,       4'hF, 1,  2,  2, 32'h0,        1, 1);
        tbl[16] = mkv(0, 1,  7, 32'h5,        4'hF, 0,  0,  7, 32'h5,        0, 1);

        for (int i = 0; i < 2; i++)
            for (int r = 0; r < 32; r++) begin
                m_mem[i][r] = 0; m_busy[i][r] = 0;
            end
        WRITE_REG = 0; WRITE_DATA = 0; WRITE_BE = 0; MARK_REG = 0;
        READREG_1 = 5; READREG_2 = 4;
        @(posedge CLK);
        do_reset();
        #1;
        check_all("reset");

        // Directed table.
        foreach (tbl[i]) begin
            cyc(tbl[i].rst, tbl[i].en, tbl[i].wr, tbl[i].wd, tbl[i].be,
                tbl[i].mk, tbl[i].mr, tbl[i].ra1, 5'd4);
            #1;
            cmp($sformatf("tbl%0d rd1", i), u0_rd1, tbl[i].x_rd);
            cmp($sformatf("tbl%0d busy1", i), {31'b0, u0_b1}, {31'b0, tbl[i].x_b});
            cmp($sformatf("tbl%0d count", i), {26'b0, u0_cnt}, {26'b0, tbl[i].x_cnt});
            check_all($sformatf("tbl%0d post", i));
        end

        // Bypass: same-cycle visibility on u0, old value on u1 until the edge.
        cyc(0, 1, 7, 32'h77, 4'hF, 0, 0, 7, 7);
        ENA_WRITE = 1; WRITE_REG = 7; WRITE_DATA = 32'h5; WRITE_BE = 4'hF;
        READREG_1 = 7;
        #1;
        cmp("bypass u0 same cycle", u0_rd1, 32'h5);
        cmp("no-bypass u1 same cycle", u1_rd1, 32'h77);
        @(posedge CLK);
        model_edge();
        #1;
        idle();
        #1;
        cmp("bypass u0 after edge", u0_rd1, 32'h5);
        cmp("no-bypass u1 after edge", u1_rd1, 32'h5);

        // Randomised traffic against the model.
        for (int n = 0; n < 600; n++) begin
            logic [4:0] w, a1;
            w  = 5'($urandom_range(0, 31));
            a1 = ($urandom_range(0, 3) == 0) ? w : 5'($urandom_range(0, 31));
            cyc(($urandom_range(0, 59) == 0), 1'($urandom), w, $urandom, 4'($urandom),
                1'($urandom), ($urandom_range(0, 3) == 0) ? w : 5'($urandom_range(0, 31)),
                a1, 5'($urandom_range(0, 31)));
        end

        // Full sweep.
        do_reset();
        for (int i = 1; i < 32; i++)
            cyc(0, 1, 5'(i), 32'(i) * 32'h01010101, 4'hF, 0, 0, 5'(i), 0);
        for (int i = 1; i < 31; i++) begin
            READREG_1 = 5'(i); READREG_2 = 5'(i + 1);
            #1;
            cmp($sformatf("sweep r%0d", i), u0_rd1, 32'(i) * 32'h01010101);
            cmp($sformatf("sweep r%0d", i + 1), u0_rd2, 32'(i + 1) * 32'h01010101);
        end
        cyc(0, 1, 0, 32'hFFFFFFFF, 4'hF, 0, 0, 0, 0);
        READREG_1 = 0;
        #1;
        cmp("sweep r0 zero reg", u0_rd1, 32'h0);
        cmp("sweep r0 plain reg", u1_rd1, 32'hFFFFFFFF);

        // Saturation of the count.
        do_reset();
        for (int i = 1; i < 32; i++) cyc(0, 0, 0, 0, 0, 1, 5'(i), 5'(i), 0);
        #1;
        cmp("sat u0 count 31", {26'b0, u0_cnt}, 32'd31);
        cmp("sat u1 count 31", {26'b0, u1_cnt}, 32'd31);
        cyc(0, 0, 0, 0, 0, 1, 0, 0, 1);
        #1;
        cmp("sat u0 mark r0", {26'b0, u0_cnt}, 32'd31);
        cmp("sat u1 mark r0", {26'b0, u1_cnt}, 32'd32);
        for (int i = 0; i < 32; i++) cyc(0, 1, 5'(i), 32'hA5A5A5A5, 4'h0, 0, 0, 5'(i), 0);
        #1;
        cmp("sat u0 drained", {26'b0, u0_cnt}, 32'd0);
        cmp("sat u1 drained", {26'b0, u1_cnt}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
